// File: rtl/nwr_pkt_builder_if.sv
// User-stream and SRIO ireq AXI-S signals of the NWRITE packet builder.
// master = generator/ireq-sink side, slave = the packet builder.
interface nwr_pkt_builder_if;
    logic [33:0] user_addr_i;
    logic [19:0] user_tsize_i;
    logic [63:0] user_tdata_i;
    logic        user_tfirst_i;
    logic        user_tvalid_i;
    logic [7:0]  user_tkeep_i;
    logic        user_tlast_i;
    logic        user_tready_o;
    logic        ireq_tvalid_o;
    logic        ireq_tready_i;
    logic [63:0] ireq_tdata_o;
    logic [7:0]  ireq_tkeep_o;
    logic        ireq_tlast_o;

    modport master (
        output user_addr_i, user_tsize_i, user_tdata_i, user_tfirst_i,
               user_tvalid_i, user_tkeep_i, user_tlast_i,
        input  user_tready_o,
        input  ireq_tvalid_o, ireq_tdata_o, ireq_tkeep_o, ireq_tlast_o,
        output ireq_tready_i
    );

    modport slave (
        input  user_addr_i, user_tsize_i, user_tdata_i, user_tfirst_i,
               user_tvalid_i, user_tkeep_i, user_tlast_i,
        output user_tready_o,
        output ireq_tvalid_o, ireq_tdata_o, ireq_tkeep_o, ireq_tlast_o,
        input  ireq_tready_i
    );
endinterface

// File: rtl/nwr_pkt_builder.sv
// Splits a user NWRITE transfer into HELLO-format packets (header beat + payload) on ireq.
// Optional length cross-check against user_tlast_i enabled by defining NWR_LEN_CHECK_EN.
module nwr_pkt_builder #(
    parameter int         MAX_PKT_BYTES = 256,
    parameter logic [1:0] PRIO          = 2'd1,
    parameter logic       CRF           = 1'b0
) (
    input  logic               log_clk,
    input  logic               log_rst_n,
    nwr_pkt_builder_if.slave   bus,
    output logic               nwr_ready_o,
    output logic               nwr_busy_o,
    output logic               nwr_done_o,
    output logic               len_err_o
);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_DONE} state_t;

    localparam logic [20:0] MAX_REM = 21'(MAX_PKT_BYTES);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [33:0] r_addr;
    logic [20:0] r_rem;
    logic [7:0]  r_tid;
    logic [8:0]  r_seg;
    logic [5:0]  r_beat_cnt;
    logic        r_hold_vld;
    logic [63:0] r_hold_data;
    logic [7:0]  r_hold_keep;

    logic [8:0]  w_seg;
    logic [7:0]  w_size;
    logic [5:0]  w_seg_beats;
    logic        w_final_beat;
    logic [20:0] w_rem_dec;
    logic        w_first_hs;
    logic        w_ireq_hs;
    logic        w_pkt_last;
    logic [63:0] w_hdr;

    assign w_seg        = (r_rem > MAX_REM) ? MAX_REM[8:0] : r_rem[8:0];
    assign w_size       = 8'(w_seg - 9'd1);
    assign w_seg_beats  = 6'((w_seg + 9'd7) >> 3);
    // The current beat is the last one of the transfer once no more than 8 bytes remain.
    assign w_final_beat = (r_rem <= 21'd8);
    assign w_rem_dec    = w_final_beat ? 21'd0 : (r_rem - 21'd8);
    assign w_first_hs   = bus.user_tvalid_i & bus.user_tfirst_i;
    assign w_ireq_hs    = bus.ireq_tvalid_o & bus.ireq_tready_i;
    assign w_pkt_last   = (r_beat_cnt == 6'd1);
    assign w_hdr        = {r_tid, 4'h5, 4'h4, 1'b0, PRIO, CRF, w_size, 2'b00, r_addr};

    always_ff @(posedge log_clk or negedge log_rst_n) begin
        if (!log_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (w_first_hs) w_state_nxt = S_HDR;
            S_HDR:   if (bus.ireq_tready_i) w_state_nxt = S_DATA;
            S_DATA:  if (w_ireq_hs && w_pkt_last) w_state_nxt = w_final_beat ? S_DONE : S_HDR;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        bus.user_tready_o = 1'b0;
        bus.ireq_tvalid_o = 1'b0;
        bus.ireq_tdata_o  = '0;
        bus.ireq_tkeep_o  = '0;
        bus.ireq_tlast_o  = 1'b0;
        nwr_ready_o       = 1'b0;
        nwr_busy_o        = 1'b0;
        nwr_done_o        = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                bus.user_tready_o = 1'b1;
                nwr_ready_o       = 1'b1;
            end
            S_HDR: begin
                nwr_busy_o        = 1'b1;
                bus.ireq_tvalid_o = 1'b1;
                bus.ireq_tdata_o  = w_hdr;
                bus.ireq_tkeep_o  = 8'hff;
            end
            S_DATA: begin
                nwr_busy_o       = 1'b1;
                bus.ireq_tlast_o = w_pkt_last;
                if (r_hold_vld) begin
                    bus.ireq_tvalid_o = 1'b1;
                    bus.ireq_tdata_o  = r_hold_data;
                    bus.ireq_tkeep_o  = w_final_beat ? r_hold_keep : 8'hff;
                end else begin
                    // Zero-bubble pass-through of the user stream.
                    bus.ireq_tvalid_o = bus.user_tvalid_i;
                    bus.user_tready_o = bus.ireq_tready_i;
                    bus.ireq_tdata_o  = bus.user_tdata_i;
                    bus.ireq_tkeep_o  = w_final_beat ? bus.user_tkeep_i : 8'hff;
                end
            end
            S_DONE: begin
                nwr_busy_o = 1'b1;
                nwr_done_o = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge log_clk or negedge log_rst_n) begin
        if (!log_rst_n) begin
            r_addr      <= '0;
            r_rem       <= '0;
            r_tid       <= '0;
            r_seg       <= '0;
            r_beat_cnt  <= '0;
            r_hold_vld  <= 1'b0;
            r_hold_data <= '0;
            r_hold_keep <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_first_hs) begin
                        r_addr      <= bus.user_addr_i;
                        r_rem       <= {1'b0, bus.user_tsize_i} + 21'd1;
                        r_hold_vld  <= 1'b1;
                        r_hold_data <= bus.user_tdata_i;
                        r_hold_keep <= bus.user_tkeep_i;
                    end
                end
                S_HDR: begin
                    if (bus.ireq_tready_i) begin
                        r_tid      <= r_tid + 8'd1;
                        r_seg      <= w_seg;
                        r_beat_cnt <= w_seg_beats;
                    end
                end
                S_DATA: begin
                    if (w_ireq_hs) begin
                        r_beat_cnt <= r_beat_cnt - 6'd1;
                        r_rem      <= w_rem_dec;
                        r_hold_vld <= 1'b0;
                        if (w_pkt_last) r_addr <= r_addr + {25'd0, r_seg};
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef NWR_LEN_CHECK_EN
    logic r_hold_last;
    logic r_len_err;
    logic w_beat_tlast;

    assign w_beat_tlast = r_hold_vld ? r_hold_last : bus.user_tlast_i;

    always_ff @(posedge log_clk or negedge log_rst_n) begin
        if (!log_rst_n) begin
            r_hold_last <= 1'b0;
            r_len_err   <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_first_hs) r_hold_last <= bus.user_tlast_i;
            if (r_state == S_DATA && w_ireq_hs && (w_beat_tlast != w_final_beat)) r_len_err <= 1'b1;
        end
    end

    assign len_err_o = r_len_err;
`else
    logic w_unused_tlast;
    assign w_unused_tlast = bus.user_tlast_i;
    assign len_err_o      = 1'b0;
`endif

endmodule

// File: tb/tb_nwr_pkt_builder.sv
// Scoreboard bench for nwr_pkt_builder: a transfer-level packet model fills the expected queue,
// a monitor pops and compares every ireq handshake.
module tb_nwr_pkt_builder;

    localparam int         MAX_PKT = 256;
    localparam logic [1:0] PRIO    = 2'd1;
    localparam logic       CRF     = 1'b0;
`ifdef NWR_LEN_CHECK_EN
    localparam logic LEN_CHK = 1'b1;
`else
    localparam logic LEN_CHK = 1'b0;
`endif

    typedef struct {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } beat_t;

    logic log_clk   = 1'b0;
    logic log_rst_n = 1'b0;
    logic nwr_ready, nwr_busy, nwr_done, len_err;

    nwr_pkt_builder_if bus ();

    nwr_pkt_builder #(.MAX_PKT_BYTES(MAX_PKT), .PRIO(PRIO), .CRF(CRF)) dut (
        .log_clk     (log_clk),
        .log_rst_n   (log_rst_n),
        .bus         (bus),
        .nwr_ready_o (nwr_ready),
        .nwr_busy_o  (nwr_busy),
        .nwr_done_o  (nwr_done),
        .len_err_o   (len_err)
    );

    always #5 log_clk = ~log_clk;

    beat_t exp_q[$];
    int    n_vec     = 0;
    int    n_err     = 0;
    int    done_cnt  = 0;
    int    tid_model = 0;
    int    sink_mode = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: cut the transfer into MAX_PKT-byte segments, header first, then payload beats.
    function automatic void push_transfer(input logic [33:0] addr, input int n_bytes,
                                          input logic [63:0] data[$], input logic [7:0] keep_final);
        int          off;
        int          bi;
        int          nb_total;
        int          seg;
        int          seg_beats;
        logic [33:0] a;
        logic [7:0]  sz;
        beat_t       b;
        off      = 0;
        bi       = 0;
        nb_total = (n_bytes + 7) / 8;
        while (off < n_bytes) begin
            seg       = (n_bytes - off > MAX_PKT) ? MAX_PKT : (n_bytes - off);
            seg_beats = (seg + 7) / 8;
            a         = addr + 34'(off);
            sz        = 8'(seg - 1);
            b.d = {8'(tid_model), 4'h5, 4'h4, 1'b0, PRIO, CRF, sz, 2'b00, a};
            b.k = 8'hff;
            b.l = 1'b0;
            exp_q.push_back(b);
            tid_model = (tid_model + 1) % 256;
            for (int k = 0; k < seg_beats; k++) begin
                b.d = data[bi];
                b.k = (bi == nb_total - 1) ? keep_final : 8'hff;
                b.l = (k == seg_beats - 1);
                exp_q.push_back(b);
                bi++;
            end
            off += seg;
        end
    endfunction

    initial begin
        bus.ireq_tready_i = 1'b0;
        forever begin
            @(posedge log_clk);
            #1;
            case (sink_mode)
                0:       bus.ireq_tready_i = 1'b1;
                1:       bus.ireq_tready_i = ($urandom_range(0, 2) != 0);
                default: bus.ireq_tready_i = ~bus.ireq_tready_i;
            endcase
        end
    end

    logic  stalled = 1'b0;
    beat_t held;
    beat_t e_mon;

    always @(negedge log_clk) begin
        if (!log_rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_data", bus.ireq_tdata_o, held.d);
                check("stall_ctl", {bus.ireq_tvalid_o, bus.ireq_tkeep_o, bus.ireq_tlast_o},
                      {1'b1, held.k, held.l});
            end
            if (bus.ireq_tvalid_o && bus.ireq_tready_i) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_beat: got %h expected none", bus.ireq_tdata_o);
                end else begin
                    e_mon = exp_q.pop_front();
                    check("ireq_data", bus.ireq_tdata_o, e_mon.d);
                    check("ireq_keep_last", {bus.ireq_tkeep_o, bus.ireq_tlast_o}, {e_mon.k, e_mon.l});
                end
            end
            stalled = bus.ireq_tvalid_o && !bus.ireq_tready_i;
            held.d  = bus.ireq_tdata_o;
            held.k  = bus.ireq_tkeep_o;
            held.l  = bus.ireq_tlast_o;
            if (nwr_done) done_cnt++;
        end
    end

    task automatic send_beat(input logic [63:0] d, input logic first, input logic last,
                             input logic [7:0] keep);
        logic hs;
        int   t;
        t = 0;
        bus.user_tdata_i  = d;
        bus.user_tfirst_i = first;
        bus.user_tlast_i  = last;
        bus.user_tkeep_i  = keep;
        bus.user_tvalid_i = 1'b1;
        do begin
            @(negedge log_clk);
            hs = bus.user_tready_o;
            @(posedge log_clk);
            #1;
            t++;
        end while (!hs && t < 2000);
        check("beat_accepted", hs, 1'b1);
        bus.user_tvalid_i = 1'b0;
        bus.user_tfirst_i = 1'b0;
        bus.user_tlast_i  = 1'b0;
    endtask

    task automatic wait_idle(input int done_before);
        int t;
        t = 0;
        do begin
            @(negedge log_clk);
            t++;
        end while (!(nwr_ready && exp_q.size() == 0) && t < 20000);
        check("idle_reached", nwr_ready, 1'b1);
        check("queue_drained", exp_q.size(), 0);
        check("done_pulses", done_cnt - done_before, 1);
        @(posedge log_clk);
        #1;
    endtask

    // tlast_idx < 0 marks the byte-count final beat with user_tlast_i.
    task automatic send_transfer(input logic [33:0] addr, input int tsize, input logic seq,
                                 input int tlast_idx, input logic gaps);
        int          nb;
        int          done0;
        logic [63:0] data[$];
        logic [7:0]  keepf;
        logic        last;
        nb    = (tsize + 1 + 7) / 8;
        done0 = done_cnt;
        keepf = 8'($urandom);
        for (int i = 0; i < nb; i++) data.push_back(seq ? 64'(i + 1) : {$urandom, $urandom});
        push_transfer(addr, tsize + 1, data, keepf);
        bus.user_addr_i  = addr;
        bus.user_tsize_i = 20'(tsize);
        for (int i = 0; i < nb; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin
                @(posedge log_clk);
                #1;
            end
            last = (tlast_idx < 0) ? (i == nb - 1) : (i == tlast_idx);
            send_beat(data[i], i == 0, last, (i == nb - 1) ? keepf : 8'($urandom));
            if (i == 0) begin
                bus.user_addr_i  = {$urandom, $urandom};
                bus.user_tsize_i = 20'($urandom);
            end
        end
        wait_idle(done0);
    endtask

    initial begin
        logic [63:0] d5[$];
        bus.user_addr_i   = '0;
        bus.user_tsize_i  = '0;
        bus.user_tdata_i  = '0;
        bus.user_tfirst_i = 1'b0;
        bus.user_tvalid_i = 1'b0;
        bus.user_tkeep_i  = '0;
        bus.user_tlast_i  = 1'b0;

        #2;
        check("rst_ready", nwr_ready, 1'b1);
        check("rst_user_tready", bus.user_tready_o, 1'b1);
        check("rst_busy_done", {nwr_busy, nwr_done, len_err}, 3'b000);
        check("rst_ireq_ctl", {bus.ireq_tvalid_o, bus.ireq_tkeep_o, bus.ireq_tlast_o}, 10'd0);
        check("rst_ireq_data", bus.ireq_tdata_o, 64'd0);
        #20;
        log_rst_n = 1'b1;
        @(posedge log_clk);
        #1;

        sink_mode = 0;
        send_transfer(34'h1000, 127, 1'b0, -1, 1'b0);
        send_transfer(34'h0, 511, 1'b1, -1, 1'b0);
        send_transfer(34'h4000, 263, 1'b0, -1, 1'b0);
        send_transfer(34'h88, 0, 1'b0, -1, 1'b0);
        sink_mode = 2;
        send_transfer(34'h0, 511, 1'b1, -1, 1'b0);

        // Reset while the fifth payload beat is on the bus.
        sink_mode = 0;
        for (int i = 0; i < 16; i++) d5.push_back({$urandom, $urandom});
        push_transfer(34'h1000, 128, d5, 8'hff);
        bus.user_addr_i  = 34'h1000;
        bus.user_tsize_i = 20'd127;
        for (int i = 0; i < 4; i++) send_beat(d5[i], i == 0, 1'b0, 8'hff);
        bus.user_tdata_i  = d5[4];
        bus.user_tvalid_i = 1'b1;
        #2;
        log_rst_n = 1'b0;
        #1;
        check("midrst_ready", {nwr_ready, bus.user_tready_o, nwr_busy, nwr_done}, 4'b1100);
        check("midrst_ireq_ctl", {bus.ireq_tvalid_o, bus.ireq_tkeep_o, bus.ireq_tlast_o}, 10'd0);
        check("midrst_ireq_data", bus.ireq_tdata_o, 64'd0);
        bus.user_tvalid_i = 1'b0;
        exp_q.delete();
        tid_model = 0;
        @(negedge log_clk);
        @(negedge log_clk);
        log_rst_n = 1'b1;
        @(posedge log_clk);
        #1;
        send_transfer(34'h2_0000, 63, 1'b0, -1, 1'b0);

        // A beat without tfirst in IDLE must vanish.
        send_beat({$urandom, $urandom}, 1'b0, 1'b1, 8'hff);
        repeat (8) @(posedge log_clk);
        #1;
        check("drop_still_idle", {nwr_ready, nwr_busy}, 2'b10);

        send_transfer(34'h3_FFFF_FF80, 511, 1'b0, -1, 1'b1);
        sink_mode = 1;
        for (int n = 0; n < 10; n++) begin
            send_transfer({$urandom, $urandom} & ~34'h7,
                          (n % 3 == 0) ? $urandom_range(0, 15) : $urandom_range(0, 1100),
                          1'b0, -1, 1'b1);
        end
        check("len_err_clean", len_err, 1'b0);

        sink_mode = 0;
        send_transfer(34'h1000, 127, 1'b0, 9, 1'b0);
        check("len_err_set", len_err, LEN_CHK);
        send_transfer(34'h5000, 40, 1'b0, -1, 1'b0);
        check("len_err_sticky", len_err, LEN_CHK);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
